// File: rtl/hs32_mem_arb_pkg.sv
// Shared encodings for the hs32 memory arbiter: FSM states, bus owners,
// bus direction and the data value returned on a bus error.
package hs32_mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_X    = 2'd2
    } owner_e;

    localparam logic        MEM_RD       = 1'b0;
    localparam logic        MEM_WR       = 1'b1;
    localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/hs32_mem_arb.sv
// Round-robin arbiter sharing one memory bus between fetch and exec, with
// registered bus/response signals, a stuck-cycle watchdog and flush discard.
module hs32_mem_arb
    import hs32_mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqf,
    input  logic [31:0] addrf,
    output logic        rdyf,
    output logic [31:0] dtrf,
    input  logic        flush,
    input  logic        reqx,
    input  logic [31:0] addrx,
    input  logic [31:0] dtwx,
    input  logic        rwx,
    output logic        rdyx,
    output logic [31:0] dtrx,
    output logic        berr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dtw,
    output logic        mem_rw,
    output logic        mem_stb,
    input  logic        mem_ack,
    input  logic [31:0] mem_dtr
);

    arb_state_e    r_state;
    owner_e        r_owner;
    owner_e        r_last;
    logic [TW-1:0] r_wdog;
    logic          r_discard;

    logic w_elig_f, w_elig_x, w_pick_f, w_pick_x, w_fdisc, w_expire;

    // A port still showing its rdy pulse has not yet dropped req; masking it
    // here keeps the lingering request from winning a second grant.
    always_comb begin
        w_elig_f = reqf & ~rdyf;
        w_elig_x = reqx & ~rdyx;
        w_pick_x = w_elig_x & (~w_elig_f | (r_last == OWN_F));
        w_pick_f = w_elig_f & ~w_pick_x;
        w_fdisc  = (r_owner == OWN_F) & (r_discard | flush);
        w_expire = (TIMEOUT != 0) && (r_wdog == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_owner   <= OWN_NONE;
            r_last    <= OWN_F;
            r_wdog    <= '0;
            r_discard <= 1'b0;
            rdyf      <= 1'b0;
            rdyx      <= 1'b0;
            berr      <= 1'b0;
            dtrf      <= '0;
            dtrx      <= '0;
            mem_addr  <= '0;
            mem_dtw   <= '0;
            mem_rw    <= MEM_RD;
            mem_stb   <= 1'b0;
        end else begin
            rdyf <= 1'b0;
            rdyx <= 1'b0;
            berr <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_x) begin
                        mem_addr <= addrx;
                        mem_dtw  <= dtwx;
                        mem_rw   <= rwx;
                        mem_stb  <= 1'b1;
                        r_owner  <= OWN_X;
                        r_last   <= OWN_X;
                        r_wdog   <= '0;
                        r_state  <= ARB_BUSY;
                    end else if (w_pick_f) begin
                        mem_addr  <= addrf;
                        mem_dtw   <= '0;
                        mem_rw    <= MEM_RD;
                        mem_stb   <= 1'b1;
                        r_owner   <= OWN_F;
                        r_last    <= OWN_F;
                        r_wdog    <= '0;
                        r_discard <= flush;
                        r_state   <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ack || w_expire) begin
                        // ack takes priority over a watchdog expiry in the same cycle
                        mem_stb   <= 1'b0;
                        r_owner   <= OWN_NONE;
                        r_discard <= 1'b0;
                        r_state   <= ARB_IDLE;
                        if (r_owner == OWN_X) begin
                            rdyx <= 1'b1;
                            berr <= ~mem_ack;
                            if (!mem_ack)
                                dtrx <= BUS_ERR_DATA;
                            else
                                dtrx <= (mem_rw == MEM_WR) ? 32'd0 : mem_dtr;
                        end else if (!w_fdisc) begin
                            rdyf <= 1'b1;
                            berr <= ~mem_ack;
                            dtrf <= mem_ack ? mem_dtr : BUS_ERR_DATA;
                        end
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                        if (flush && r_owner == OWN_F)
                            r_discard <= 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Directed bench for hs32_mem_arb with TIMEOUT=4; memory is driven by hand.
module tb_hs32_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqf, reqx, flush, rwx, mem_ack;
    logic [31:0] addrf, addrx, dtwx, mem_dtr;
    logic        rdyf, rdyx, berr, mem_rw, mem_stb;
    logic [31:0] dtrf, dtrx, mem_addr, mem_dtw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hs32_mem_arb #(.TIMEOUT(4), .TW(8)) dut (
        .clk(clk), .reset(reset),
        .reqf(reqf), .addrf(addrf), .rdyf(rdyf), .dtrf(dtrf),
        .flush(flush),
        .reqx(reqx), .addrx(addrx), .dtwx(dtwx), .rwx(rwx),
        .rdyx(rdyx), .dtrx(dtrx), .berr(berr),
        .mem_addr(mem_addr), .mem_dtw(mem_dtw), .mem_rw(mem_rw),
        .mem_stb(mem_stb), .mem_ack(mem_ack), .mem_dtr(mem_dtr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; reqf = 0; reqx = 0; flush = 0; rwx = 0; mem_ack = 0;
        addrf = 0; addrx = 0; dtwx = 0; mem_dtr = 0;
        #1;
        checks++; if ({mem_stb, rdyf, rdyx, berr, mem_rw} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b exp 00000", {mem_stb, rdyf, rdyx, berr, mem_rw}); end
        checks++; if ({mem_addr, mem_dtw, dtrf, dtrx} !== 128'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_dtw, dtrf, dtrx}); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++; if (mem_stb !== 1'b0) begin errors++; $display("FAIL reset_idle stb got %b exp 0", mem_stb); end
    endtask

    task automatic test_round_robin();
        logic [31:0] ea;
        bit          isx;
        reqf = 1; addrf = 32'hA0; reqx = 1; addrx = 32'hB0; rwx = 0; mem_ack = 1;
        for (int i = 0; i < 4; i++) begin
            isx = (i % 2 == 0);
            ea = isx ? 32'hB0 : 32'hA0;
            mem_dtr = 32'h1000 + i;
            tick();
            checks++; if (mem_stb !== 1'b1 || mem_addr !== ea || mem_rw !== 1'b0) begin errors++; $display("FAIL rr_grant%0d got stb=%b addr=%h rw=%b exp stb=1 addr=%h rw=0", i, mem_stb, mem_addr, mem_rw, ea); end
            tick();
            if (i == 3) begin reqf = 0; reqx = 0; end
            checks++; if (rdyx !== isx || rdyf !== !isx || mem_stb !== 1'b0) begin errors++; $display("FAIL rr_done%0d got rdyx=%b rdyf=%b stb=%b exp rdyx=%b rdyf=%b stb=0", i, rdyx, rdyf, mem_stb, isx, !isx); end
            checks++; if ((isx ? dtrx : dtrf) !== 32'h1000 + i) begin errors++; $display("FAIL rr_data%0d got %h exp %h", i, isx ? dtrx : dtrf, 32'h1000 + i); end
        end
        mem_ack = 0;
        tick();
        checks++; if (mem_stb !== 1'b0) begin errors++; $display("FAIL rr_nogrant stb got %b exp 0", mem_stb); end
    endtask

    task automatic test_exec_read();
        reqx = 1; addrx = 32'h100; rwx = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (mem_stb !== 1'b1 || mem_addr !== 32'h100 || rdyx !== 1'b0) begin errors++; $display("FAIL rd_busy%0d got stb=%b addr=%h rdyx=%b exp 1 100 0", c, mem_stb, mem_addr, rdyx); end
        end
        mem_ack = 1; mem_dtr = 32'hDEADBEEF;
        tick();
        mem_ack = 0;
        checks++; if (mem_stb !== 1'b0 || rdyx !== 1'b1 || dtrx !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_done got stb=%b rdyx=%b dtrx=%h exp 0 1 deadbeef", mem_stb, rdyx, dtrx); end
        tick();
        reqx = 0;
        checks++; if (mem_stb !== 1'b0 || rdyx !== 1'b0) begin errors++; $display("FAIL rd_linger got stb=%b rdyx=%b exp 0 0", mem_stb, rdyx); end
    endtask

    task automatic test_exec_write();
        reqx = 1; addrx = 32'h200; dtwx = 32'h12345678; rwx = 1; mem_dtr = 32'hCAFEF00D;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++; if (mem_stb !== 1'b1 || mem_addr !== 32'h200 || mem_dtw !== 32'h12345678 || mem_rw !== 1'b1) begin errors++; $display("FAIL wr_bus%0d got stb=%b addr=%h dtw=%h rw=%b exp 1 200 12345678 1", c, mem_stb, mem_addr, mem_dtw, mem_rw); end
        end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        checks++; if (rdyx !== 1'b1 || dtrx !== 32'd0 || berr !== 1'b0) begin errors++; $display("FAIL wr_done got rdyx=%b dtrx=%h berr=%b exp 1 0 0", rdyx, dtrx, berr); end
        tick();
        reqx = 0; rwx = 0; dtwx = 0;
    endtask

    task automatic test_watchdog();
        reqx = 1; addrx = 32'h300; rwx = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++; if (mem_stb !== 1'b1 || berr !== 1'b0) begin errors++; $display("FAIL wd_busy%0d got stb=%b berr=%b exp 1 0", c, mem_stb, berr); end
        end
        tick();
        checks++; if (mem_stb !== 1'b0 || rdyx !== 1'b1 || berr !== 1'b1 || dtrx !== 32'hFFFFFFFF) begin errors++; $display("FAIL wd_expire got stb=%b rdyx=%b berr=%b dtrx=%h exp 0 1 1 ffffffff", mem_stb, rdyx, berr, dtrx); end
        tick();
        checks++; if (berr !== 1'b0 || rdyx !== 1'b0 || mem_stb !== 1'b0) begin errors++; $display("FAIL wd_pulse got berr=%b rdyx=%b stb=%b exp 0 0 0", berr, rdyx, mem_stb); end
        // second run: ack lands in the expiry cycle
        for (int c = 1; c <= 4; c++) tick();
        checks++; if (mem_stb !== 1'b1) begin errors++; $display("FAIL wd2_busy got stb=%b exp 1", mem_stb); end
        mem_ack = 1; mem_dtr = 32'h55AA55AA;
        tick();
        mem_ack = 0;
        checks++; if (rdyx !== 1'b1 || berr !== 1'b0 || dtrx !== 32'h55AA55AA) begin errors++; $display("FAIL wd2_ackwins got rdyx=%b berr=%b dtrx=%h exp 1 0 55aa55aa", rdyx, berr, dtrx); end
        tick();
        reqx = 0;
    endtask

    task automatic test_flush();
        reqf = 1; addrf = 32'h400;
        tick();
        checks++; if (mem_stb !== 1'b1 || mem_addr !== 32'h400 || mem_rw !== 1'b0 || mem_dtw !== 32'd0) begin errors++; $display("FAIL fl_grant got stb=%b addr=%h rw=%b dtw=%h exp 1 400 0 0", mem_stb, mem_addr, mem_rw, mem_dtw); end
        flush = 1; reqf = 0;
        tick();
        flush = 0;
        tick();
        mem_ack = 1; mem_dtr = 32'h777;
        tick();
        mem_ack = 0;
        checks++; if (mem_stb !== 1'b0 || rdyf !== 1'b0 || berr !== 1'b0) begin errors++; $display("FAIL fl_suppress got stb=%b rdyf=%b berr=%b exp 0 0 0", mem_stb, rdyf, berr); end
        reqf = 1; addrf = 32'h404;
        tick();
        checks++; if (mem_stb !== 1'b1 || mem_addr !== 32'h404) begin errors++; $display("FAIL fl_refetch got stb=%b addr=%h exp 1 404", mem_stb, mem_addr); end
        mem_ack = 1; mem_dtr = 32'h888;
        tick();
        mem_ack = 0;
        checks++; if (rdyf !== 1'b1 || dtrf !== 32'h888) begin errors++; $display("FAIL fl_next got rdyf=%b dtrf=%h exp 1 888", rdyf, dtrf); end
        tick();
        reqf = 0;
        // flush during an exec-owned cycle changes nothing
        reqx = 1; addrx = 32'h500;
        tick();
        flush = 1;
        tick();
        flush = 0; mem_ack = 1; mem_dtr = 32'h999;
        tick();
        mem_ack = 0;
        checks++; if (rdyx !== 1'b1 || dtrx !== 32'h999) begin errors++; $display("FAIL fl_exec got rdyx=%b dtrx=%h exp 1 999", rdyx, dtrx); end
        tick();
        reqx = 0;
    endtask

    task automatic test_reset_busy();
        reqx = 1; addrx = 32'h600;
        tick();
        checks++; if (mem_stb !== 1'b1) begin errors++; $display("FAIL rb_busy got stb=%b exp 1", mem_stb); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({mem_stb, rdyf, rdyx, berr} !== 4'b0 || mem_addr !== 32'd0) begin errors++; $display("FAIL rb_async got ctl=%b addr=%h exp 0000 0", {mem_stb, rdyf, rdyx, berr}, mem_addr); end
        reqf = 1; addrf = 32'h700; addrx = 32'h800;
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++; if (mem_stb !== 1'b1 || mem_addr !== 32'h800) begin errors++; $display("FAIL rb_tie got stb=%b addr=%h exp 1 800", mem_stb, mem_addr); end
        mem_ack = 1; mem_dtr = 32'hAB;
        tick();
        checks++; if (rdyx !== 1'b1 || rdyf !== 1'b0) begin errors++; $display("FAIL rb_done got rdyx=%b rdyf=%b exp 1 0", rdyx, rdyf); end
        reqx = 0;
        tick();
        checks++; if (mem_stb !== 1'b1 || mem_addr !== 32'h700) begin errors++; $display("FAIL rb_fetch got stb=%b addr=%h exp 1 700", mem_stb, mem_addr); end
        tick();
        mem_ack = 0; reqf = 0;
        checks++; if (rdyf !== 1'b1 || rdyx !== 1'b0 || dtrf !== 32'hAB) begin errors++; $display("FAIL rb_fdone got rdyf=%b rdyx=%b dtrf=%h exp 1 0 ab", rdyf, rdyx, dtrf); end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_exec_read();
        test_exec_write();
        test_watchdog();
        test_flush();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
